// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the framebuffer port-A arbiter.
//   FB_WIDTH / FB_DEPTH : default pixel width and framebuffer depth
//   REQ_CPU / REQ_BLIT  : requester IDs carried through the read tag pipe
//   fbArbState_t        : arbiter FSM states
//   fbTag_t             : {valid, id} read-return tag
package fb_arb_pkg;

  localparam int unsigned FB_WIDTH = 9;
  localparam int unsigned FB_DEPTH = 2048;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_BLIT = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fbArbState_t;

  typedef struct packed {
    logic valid;
    logic id;
  } fbTag_t;

endpackage

// File: rtl/framebuffer_port_arbiter_if.sv
// One requester's access channel to framebuffer port A.
//   req/we/addr/wdata : command from the requester, held until gnt
//   gnt               : combinational accept strobe
//   rvalid/rdata      : read return, rdata meaningful while rvalid is high
// master = requester side, slave = arbiter side.
interface framebuffer_port_arbiter_if
  import fb_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned ADDR_W = $clog2(FB_DEPTH)
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic              gnt;
  logic              rvalid;
  logic [WIDTH-1:0]  rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/fb_rr_arbiter.sv
// Two-way round-robin grant logic with a one-bit priority pointer.
//   clk, nReset       : clock, asynchronous active-low reset
//   req0, req1        : qualified requests (already masked while blocked)
//   gnt0_c, gnt1_c    : combinational grants, at most one high
// The pointer names the winner under contention and flips only when both
// requests were pending, so an uncontended requester never disturbs fairness.
module fb_rr_arbiter
  import fb_arb_pkg::*;
(
  input  logic clk,
  input  logic nReset,
  input  logic req0,
  input  logic req1,
  output logic gnt0_c,
  output logic gnt1_c
);

  logic prio;

  // Lone request always wins; contention is settled by the pointer.
  assign gnt0_c = req0 & (~req1 | (prio == REQ_CPU));
  assign gnt1_c = req1 & (~req0 | (prio == REQ_BLIT));

  // Pointer moves to the loser after every contended grant.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      prio <= REQ_CPU;
    end else if (req0 && req1) begin
      prio <= ~prio;
    end
  end

endmodule

// File: rtl/framebuffer_port_arbiter.sv
// Shares framebuffer port A between the CPU bridge (port0) and the blitter
// (port1); port B is left to video scan-out.
//   clk, nReset           : clock, asynchronous active-low reset
//   port0, port1          : requester channels (slave modport)
//   fbAddress/fbDataIn/
//   fbWriteEnable         : registered command to the RAM
//   fbDataOut             : RAM read data, one cycle after address sample
//   clearStart/clearValue : start a whole-framebuffer fill
//   clearBusy             : high while the fill runs
// Build option FB_ARB_CLEAR_EN adds the clear sequencer and CLEAR state;
// without it the clear inputs are ignored and clearBusy is tied low.
module framebuffer_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned WIDTH = FB_WIDTH,
  parameter int unsigned DEPTH = FB_DEPTH
) (
  input  logic                     clk,
  input  logic                     nReset,
  framebuffer_port_arbiter_if.slave port0,
  framebuffer_port_arbiter_if.slave port1,
  output logic [$clog2(DEPTH)-1:0] fbAddress,
  output logic [WIDTH-1:0]         fbDataIn,
  output logic                     fbWriteEnable,
  input  logic [WIDTH-1:0]         fbDataOut,
  input  logic                     clearStart,
  input  logic [WIDTH-1:0]         clearValue,
  output logic                     clearBusy
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  fbArbState_t       state;
  fbArbState_t       stateNext;
  logic              blockReq;
  logic              grant0;
  logic              grant1;
  logic              cmdValid;
  logic              cmdWe;
  logic              cmdId;
  logic [ADDR_W-1:0] cmdAddr;
  logic [WIDTH-1:0]  cmdData;
  fbTag_t            tagS1;
  fbTag_t            tagS2;
  logic              rvalid0;
  logic              rvalid1;

`ifdef FB_ARB_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] clearCount;
  logic [WIDTH-1:0]  clearValueQ;
  logic              clearBusyQ;
  logic              clearWrite;
  logic              clearDone;

  assign clearDone = (clearCount == LAST_ADDR);
`else
  logic unusedClear;
  assign unusedClear = ^{clearStart, clearValue};
`endif

  // Round-robin grant; requests are masked while a clear owns the port.
  fb_rr_arbiter uArb (
    .clk    (clk),
    .nReset (nReset),
    .req0   (port0.req & ~blockReq),
    .req1   (port1.req & ~blockReq),
    .gnt0_c (grant0),
    .gnt1_c (grant1)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state logic.
  always_comb begin
    stateNext = state;
`ifdef FB_ARB_CLEAR_EN
    case (state)
      ST_IDLE:  if (clearStart) stateNext = ST_CLEAR;
      ST_CLEAR: if (clearDone)  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
`else
    stateNext = ST_IDLE;
`endif
  end

  // FSM outputs: a starting or running clear blocks both requesters.
  always_comb begin
    blockReq = 1'b0;
`ifdef FB_ARB_CLEAR_EN
    clearWrite = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
`ifdef FB_ARB_CLEAR_EN
        blockReq = clearStart;
`endif
      end
      ST_CLEAR: begin
        blockReq = 1'b1;
`ifdef FB_ARB_CLEAR_EN
        clearWrite = 1'b1;
`endif
      end
      default: blockReq = 1'b0;
    endcase
  end

  // Command select: clear write, else the granted requester.
  always_comb begin
    cmdValid = 1'b0;
    cmdWe    = 1'b0;
    cmdId    = REQ_CPU;
    cmdAddr  = port0.addr;
    cmdData  = port0.wdata;
`ifdef FB_ARB_CLEAR_EN
    if (clearWrite) begin
      cmdValid = 1'b1;
      cmdWe    = 1'b1;
      cmdAddr  = clearCount;
      cmdData  = clearValueQ;
    end else
`endif
    if (grant0) begin
      cmdValid = 1'b1;
      cmdWe    = port0.we;
      cmdId    = REQ_CPU;
      cmdAddr  = port0.addr;
      cmdData  = port0.wdata;
    end else if (grant1) begin
      cmdValid = 1'b1;
      cmdWe    = port1.we;
      cmdId    = REQ_BLIT;
      cmdAddr  = port1.addr;
      cmdData  = port1.wdata;
    end
  end

`ifdef FB_ARB_CLEAR_EN
  // Clear sequencer: fill value and address counter.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      clearCount  <= '0;
      clearValueQ <= '0;
      clearBusyQ  <= 1'b0;
    end else begin
      clearBusyQ <= (stateNext == ST_CLEAR);
      if (state == ST_IDLE && clearStart) begin
        clearCount  <= '0;
        clearValueQ <= clearValue;
      end else if (state == ST_CLEAR) begin
        clearCount <= clearCount + ADDR_W'(1);
      end
    end
  end

  assign clearBusy = clearBusyQ;
`else
  assign clearBusy = 1'b0;
`endif

  // Command register to the RAM plus the two-stage read tag pipe.
  // Address/data hold when idle so the RAM sees no needless toggling.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      fbAddress     <= '0;
      fbDataIn      <= '0;
      fbWriteEnable <= 1'b0;
      tagS1         <= '0;
      tagS2         <= '0;
    end else begin
      fbWriteEnable <= cmdValid & cmdWe;
      if (cmdValid) begin
        fbAddress <= cmdAddr;
        fbDataIn  <= cmdData;
      end
      tagS1.valid <= cmdValid & ~cmdWe;
      tagS1.id    <= cmdId;
      tagS2       <= tagS1;
    end
  end

  // Read return steering.
  assign rvalid0 = tagS2.valid && (tagS2.id == REQ_CPU);
  assign rvalid1 = tagS2.valid && (tagS2.id == REQ_BLIT);

  assign port0.gnt    = grant0;
  assign port1.gnt    = grant1;
  assign port0.rvalid = rvalid0;
  assign port1.rvalid = rvalid1;
  assign port0.rdata  = rvalid0 ? fbDataOut : '0;
  assign port1.rdata  = rvalid1 ? fbDataOut : '0;

endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
// Directed bench for framebuffer_port_arbiter with a behavioural port-A RAM.
// Clear-sequencer sequences are built only with FB_ARB_CLEAR_EN.
module tb_framebuffer_port_arbiter;
  import fb_arb_pkg::*;

  localparam int unsigned WIDTH  = 9;
  localparam int unsigned DEPTH  = 2048;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned NV     = 20;

  logic              clk;
  logic              nReset;
  logic [ADDR_W-1:0] fbAddress;
  logic [WIDTH-1:0]  fbDataIn;
  logic              fbWriteEnable;
  logic [WIDTH-1:0]  fbDataOut;
  logic              clearStart;
  logic [WIDTH-1:0]  clearValue;
  logic              clearBusy;

  int total;
  int bad;

  framebuffer_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) if0 ();
  framebuffer_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) if1 ();

  framebuffer_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .nReset        (nReset),
    .port0         (if0),
    .port1         (if1),
    .fbAddress     (fbAddress),
    .fbDataIn      (fbDataIn),
    .fbWriteEnable (fbWriteEnable),
    .fbDataOut     (fbDataOut),
    .clearStart    (clearStart),
    .clearValue    (clearValue),
    .clearBusy     (clearBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read-first RAM standing in for framebuffer port A.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (fbWriteEnable) mem[fbAddress] <= fbDataIn;
    fbDataOut <= mem[fbAddress];
  end

  typedef struct {
    logic r0; logic w0; logic [ADDR_W-1:0] a0; logic [WIDTH-1:0] d0;
    logic r1; logic w1; logic [ADDR_W-1:0] a1; logic [WIDTH-1:0] d1;
    logic g0; logic g1; logic v0; logic v1;
    logic [WIDTH-1:0] q0; logic [WIDTH-1:0] q1;
    logic we;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(
    input int unsigned r0, input int unsigned w0, input int unsigned a0, input int unsigned d0,
    input int unsigned r1, input int unsigned w1, input int unsigned a1, input int unsigned d1,
    input int unsigned g0, input int unsigned g1, input int unsigned v0, input int unsigned v1,
    input int unsigned q0, input int unsigned q1, input int unsigned we);
    vec_t v;
    v.r0 = 1'(r0); v.w0 = 1'(w0); v.a0 = ADDR_W'(a0); v.d0 = WIDTH'(d0);
    v.r1 = 1'(r1); v.w1 = 1'(w1); v.a1 = ADDR_W'(a1); v.d1 = WIDTH'(d1);
    v.g0 = 1'(g0); v.g1 = 1'(g1); v.v0 = 1'(v0); v.v1 = 1'(v1);
    v.q0 = WIDTH'(q0); v.q1 = WIDTH'(q1); v.we = 1'(we);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(
    input int unsigned r0, input int unsigned w0, input int unsigned a0, input int unsigned d0,
    input int unsigned r1, input int unsigned w1, input int unsigned a1, input int unsigned d1);
    if0.req = 1'(r0); if0.we = 1'(w0); if0.addr = ADDR_W'(a0); if0.wdata = WIDTH'(d0);
    if1.req = 1'(r1); if1.we = 1'(w1); if1.addr = ADDR_W'(a1); if1.wdata = WIDTH'(d1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busyCnt;
    int g1Seen;
    total = 0;
    bad   = 0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    clearStart = 1'b0;
    clearValue = '0;
    nReset     = 1'b1;

    // r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 v0 v1 q0 q1 we
    vecs[0]  = mk(1, 1, 'h010, 'h1AB, 0, 0, 0,     0,     1, 0, 0, 0, 0,     0,     0);
    vecs[1]  = mk(1, 0, 'h010, 0,     0, 0, 0,     0,     1, 0, 0, 0, 0,     0,     1);
    vecs[2]  = mk(0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0, 0, 0,     0,     0);
    vecs[3]  = mk(0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 1, 0, 'h1AB, 0,     0);
    vecs[4]  = mk(0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0, 0, 0,     0,     0);
    vecs[5]  = mk(0, 0, 0,     0,     1, 1, 'h002, 'h0B2, 0, 1, 0, 0, 0,     0,     0);
    vecs[6]  = mk(1, 1, 'h001, 'h0A1, 0, 0, 0,     0,     1, 0, 0, 0, 0,     0,     1);
    vecs[7]  = mk(1, 0, 'h001, 0,     1, 0, 'h002, 0,     1, 0, 0, 0, 0,     0,     1);
    vecs[8]  = mk(1, 0, 'h001, 0,     1, 0, 'h002, 0,     0, 1, 0, 0, 0,     0,     0);
    vecs[9]  = mk(1, 0, 'h001, 0,     1, 0, 'h002, 0,     1, 0, 1, 0, 'h0A1, 0,     0);
    vecs[10] = mk(1, 0, 'h001, 0,     1, 0, 'h002, 0,     0, 1, 0, 1, 0,     'h0B2, 0);
    vecs[11] = mk(0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 1, 0, 'h0A1, 0,     0);
    vecs[12] = mk(0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0, 1, 0,     'h0B2, 0);
    vecs[13] = mk(0, 0, 0,     0,     1, 0, 'h010, 0,     0, 1, 0, 0, 0,     0,     0);
    vecs[14] = mk(0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0, 0, 0,     0,     0);
    vecs[15] = mk(0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0, 1, 0,     'h1AB, 0);
    vecs[16] = mk(1, 1, 'h7FF, 'h155, 0, 0, 0,     0,     1, 0, 0, 0, 0,     0,     0);
    vecs[17] = mk(0, 0, 0,     0,     1, 1, 'h000, 'h0CC, 0, 1, 0, 0, 0,     0,     1);
    vecs[18] = mk(0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0, 0, 0,     0,     1);
    vecs[19] = mk(0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0, 0, 0,     0,     0);

    // Reset values.
    #2 nReset = 1'b0;
    #1;
    chk("rst gnt0", if0.gnt, 0);
    chk("rst gnt1", if1.gnt, 0);
    chk("rst rvalid0", if0.rvalid, 0);
    chk("rst rvalid1", if1.rvalid, 0);
    chk("rst rdata0", if0.rdata, 0);
    chk("rst rdata1", if1.rdata, 0);
    chk("rst fbWriteEnable", fbWriteEnable, 0);
    chk("rst fbAddress", fbAddress, 0);
    chk("rst fbDataIn", fbDataIn, 0);
    chk("rst clearBusy", clearBusy, 0);
    @(negedge clk);
    nReset = 1'b1;

    // Table: one row per cycle, driven and checked in the low phase.
    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      drv(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
          vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("v%0d gnt0", i), if0.gnt, vecs[i].g0);
      chk($sformatf("v%0d gnt1", i), if1.gnt, vecs[i].g1);
      chk($sformatf("v%0d rvalid0", i), if0.rvalid, vecs[i].v0);
      chk($sformatf("v%0d rvalid1", i), if1.rvalid, vecs[i].v1);
      chk($sformatf("v%0d fbWriteEnable", i), fbWriteEnable, vecs[i].we);
      if (vecs[i].v0) chk($sformatf("v%0d rdata0", i), if0.rdata, vecs[i].q0);
      if (vecs[i].v1) chk($sformatf("v%0d rdata1", i), if1.rdata, vecs[i].q1);
    end

`ifdef FB_ARB_CLEAR_EN
    // Read granted the cycle before a clear, then a clear with req1 waiting.
    @(negedge clk);
    drv(1, 0, 'h010, 0, 0, 0, 0, 0);
    #1 chk("preclr gnt0", if0.gnt, 1);
    @(negedge clk);
    drv(0, 0, 0, 0, 1, 0, 'h7FF, 0);
    clearStart = 1'b1;
    clearValue = '0;
    #1;
    chk("clrstart gnt1", if1.gnt, 0);
    chk("clrstart busy", clearBusy, 0);
    @(negedge clk);
    clearStart = 1'b0;
    #1;
    chk("preclr rvalid0", if0.rvalid, 1);
    chk("preclr rdata0", if0.rdata, 'h1AB);
    busyCnt = 0;
    g1Seen  = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      if (clearBusy) busyCnt++;
      if (if1.gnt) g1Seen++;
    end
    chk("clr busy cycles", busyCnt, DEPTH);
    chk("clr gnt1 during", g1Seen, 0);
    @(negedge clk);
    #1;
    chk("clr end busy", clearBusy, 0);
    chk("clr end gnt1", if1.gnt, 1);
    @(negedge clk);
    drv(1, 0, 'h000, 0, 0, 0, 0, 0);
    #1 chk("postclr gnt0", if0.gnt, 1);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("postclr rvalid1", if1.rvalid, 1);
    chk("postclr rdata1 7FF", if1.rdata, 0);
    @(negedge clk);
    #1;
    chk("postclr rvalid0", if0.rvalid, 1);
    chk("postclr rdata0 000", if0.rdata, 0);

    // Reset in the middle of a clear.
    @(negedge clk);
    clearStart = 1'b1;
    clearValue = WIDTH'('h0AA);
    @(negedge clk);
    clearStart = 1'b0;
    repeat (256) @(negedge clk);
    #1;
    chk("midclr busy", clearBusy, 1);
    chk("midclr fbAddress", fbAddress, 'h0FF);
    nReset = 1'b0;
    #1;
    chk("midclr rst busy", clearBusy, 0);
    chk("midclr rst fbWriteEnable", fbWriteEnable, 0);
    @(negedge clk);
    nReset = 1'b1;
    drv(1, 0, 'h001, 0, 0, 0, 0, 0);
    #1 chk("midclr after gnt0", if0.gnt, 1);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("midclr after rvalid0", if0.rvalid, 1);
    chk("midclr after rdata0", if0.rdata, 'h0AA);
`else
    // Clear sequencer absent: clearStart must not block or raise busy.
    @(negedge clk);
    drv(1, 0, 'h001, 0, 0, 0, 0, 0);
    clearStart = 1'b1;
    clearValue = WIDTH'('h1FF);
    #1;
    chk("noclr gnt0", if0.gnt, 1);
    chk("noclr busy0", clearBusy, 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    clearStart = 1'b0;
    #1 chk("noclr busy1", clearBusy, 0);
    @(negedge clk);
    #1;
    chk("noclr rvalid0", if0.rvalid, 1);
    chk("noclr rdata0", if0.rdata, 'h0A1);
    chk("noclr busy2", clearBusy, 0);
`endif

    // Reset with a write in flight drops the RAM command at once.
    @(negedge clk);
    drv(1, 1, 'h003, 'h033, 0, 0, 0, 0);
    #1 chk("rstwr gnt0", if0.gnt, 1);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rstwr we before", fbWriteEnable, 1);
    chk("rstwr data before", fbDataIn, 'h033);
    nReset = 1'b0;
    #1;
    chk("rstwr we", fbWriteEnable, 0);
    chk("rstwr addr", fbAddress, 0);
    chk("rstwr data", fbDataIn, 0);
    @(negedge clk);
    nReset = 1'b1;
    drv(1, 1, 'h004, 'h044, 1, 1, 'h005, 'h055);
    #1;
    chk("rstwr ptr gnt0", if0.gnt, 1);
    chk("rstwr ptr gnt1", if1.gnt, 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
